// File: rtl/startup_edge_sequencer_pkg.sv
// Shared types and default parameters for startup_edge_sequencer.
// Optional feature macro: STARTUP_SEQ_RESTART_EN (see top-level file).
package startup_edge_sequencer_pkg;

  localparam int unsigned DEF_CHANNELS    = 4;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/startup_edge_sequencer_sync_ladder.sv
// Flop-chain synchroniser with all taps exported; taps[0] is the output stage,
// taps[STAGES-1] is the first stage fed directly by din.
module sync_ladder #(
  parameter int unsigned STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic [STAGES-1:0] taps
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps[STAGES-1] <= din;
      for (int unsigned i = 0; i + 1 < STAGES; i++) begin
        taps[i] <= taps[i+1];
      end
    end
  end

endmodule

// File: rtl/startup_edge_sequencer.sv
// Multi-channel startup edge generator: synchronised enable, per-channel release
// delays, sticky levels and one-cycle pulses. Macro STARTUP_SEQ_RESTART_EN enables re-arm from DONE.
module startup_edge_sequencer
  import startup_edge_sequencer_pkg::*;
#(
  parameter int unsigned CHANNELS    = DEF_CHANNELS,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      restart,
  input  logic [CHANNELS*CNT_W-1:0] cfg_delay,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       pulse,
  output logic                      busy,
  output logic                      done,
  output logic [SYNC_STAGES-1:0]    sync_taps
);

  seq_state_t          state;
  logic [CNT_W-1:0]    counter;
  logic [CNT_W-1:0]    dly [CHANNELS];
  logic [CHANNELS-1:0] hit;
  logic                en_s;
  logic                restart_go;

  sync_ladder #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (enable),
    .taps (sync_taps)
  );

  assign en_s = sync_taps[0];

`ifdef STARTUP_SEQ_RESTART_EN
  assign restart_go = restart;
`else
  logic unused_restart;
  assign unused_restart = restart;
  assign restart_go     = 1'b0;
`endif

  // Level doubles as the released mask, so a channel can only fire once per run.
  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!level[k] && (dly[k] == counter)) hit[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      counter <= '0;
      level   <= '0;
      pulse   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) dly[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          counter <= '0;
          level   <= '0;
          pulse   <= '0;
          done    <= 1'b0;
          busy    <= 1'b0;
          if (en_s) begin
            state <= ST_COUNT;
            busy  <= 1'b1;
            for (int unsigned k = 0; k < CHANNELS; k++) dly[k] <= cfg_delay[k*CNT_W +: CNT_W];
          end
        end
        ST_COUNT: begin
          if (!en_s) begin
            state   <= ST_IDLE;
            counter <= '0;
            level   <= '0;
            pulse   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else begin
            level <= level | hit;
            pulse <= hit;
            if (counter != '1) counter <= counter + 1'b1;
            if ((level | hit) == '1) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          pulse <= '0;
          if (!en_s) begin
            state   <= ST_IDLE;
            counter <= '0;
            level   <= '0;
            done    <= 1'b0;
          end else if (restart_go) begin
            state   <= ST_COUNT;
            counter <= '0;
            level   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            for (int unsigned k = 0; k < CHANNELS; k++) dly[k] <= cfg_delay[k*CNT_W +: CNT_W];
          end
        end
        default: begin
          state   <= ST_IDLE;
          counter <= '0;
          level   <= '0;
          pulse   <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_startup_edge_sequencer.sv
// Self-checking bench for startup_edge_sequencer (default parameters) against a
// timeline model: outputs derived from edges elapsed since the run began.
module tb_startup_edge_sequencer;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int SS = 2;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             restart;
  logic [CH*CW-1:0] cfg_delay;
  logic [CH-1:0]    level;
  logic [CH-1:0]    pulse;
  logic             busy;
  logic             done;
  logic [SS-1:0]    sync_taps;

  int vectors    = 0;
  int miscompares = 0;

  // Model: t = edges since COUNT was entered (-1 when idle), lat = latched delays.
  int   t = -1;
  int   lat [CH];
  logic hist [SS];
  bit   restart_en;

  startup_edge_sequencer #(
    .CHANNELS   (CH),
    .CNT_W      (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .restart  (restart),
    .cfg_delay(cfg_delay),
    .level    (level),
    .pulse    (pulse),
    .busy     (busy),
    .done     (done),
    .sync_taps(sync_taps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int max_lat();
    int m = 0;
    for (int k = 0; k < CH; k++) if (lat[k] > m) m = lat[k];
    return m;
  endfunction

  task automatic model_reset();
    t = -1;
    for (int i = 0; i < SS; i++) hist[i] = 1'b0;
    for (int k = 0; k < CH; k++) lat[k] = 0;
  endtask

  task automatic model_edge(input logic en, input logic rs, input logic [CH*CW-1:0] cfg);
    logic en_s_prev;
    bit   fin;
    logic [CH*CW-1:0] c;
    en_s_prev = hist[0];
    c = cfg;
    fin = (t >= 0) && (t >= 1 + max_lat());
    if (t < 0) begin
      if (en_s_prev) begin
        t = 0;
        for (int k = 0; k < CH; k++) lat[k] = int'(c[k*CW +: CW]);
      end
    end else if (!en_s_prev) begin
      t = -1;
    end else if (restart_en && fin && rs) begin
      t = 0;
      for (int k = 0; k < CH; k++) lat[k] = int'(c[k*CW +: CW]);
    end else if (t < 100000) begin
      t = t + 1;
    end
    for (int i = 0; i + 1 < SS; i++) hist[i] = hist[i+1];
    hist[SS-1] = en;
  endtask

  task automatic check(input string tag);
    logic [CH-1:0] e_level, e_pulse;
    logic          e_busy, e_done;
    logic [SS-1:0] e_taps;
    e_level = '0;
    e_pulse = '0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    for (int i = 0; i < SS; i++) e_taps[i] = hist[i];
    if (t >= 0) begin
      for (int k = 0; k < CH; k++) begin
        e_level[k] = (t >= 1 + lat[k]);
        e_pulse[k] = (t == 1 + lat[k]);
      end
      e_done = (t >= 1 + max_lat());
      e_busy = !e_done;
    end
    vectors += 5;
    assert (level === e_level) else begin
      miscompares++; $error("FAIL %s level got %b want %b", tag, level, e_level);
    end
    assert (pulse === e_pulse) else begin
      miscompares++; $error("FAIL %s pulse got %b want %b", tag, pulse, e_pulse);
    end
    assert (busy === e_busy) else begin
      miscompares++; $error("FAIL %s busy got %b want %b", tag, busy, e_busy);
    end
    assert (done === e_done) else begin
      miscompares++; $error("FAIL %s done got %b want %b", tag, done, e_done);
    end
    assert (sync_taps === e_taps) else begin
      miscompares++; $error("FAIL %s sync_taps got %b want %b", tag, sync_taps, e_taps);
    end
  endtask

  task automatic step(input logic en, input logic rs, input logic [CH*CW-1:0] cfg, input string tag);
    enable    = en;
    restart   = rs;
    cfg_delay = cfg;
    @(posedge clk);
    if (rst_n) model_edge(en, rs, cfg);
    #1;
    check(tag);
  endtask

  task automatic expect_pulse(input logic [CH-1:0] want, input logic want_done, input string tag);
    vectors += 2;
    assert (pulse === want) else begin
      miscompares++; $error("FAIL %s pulse got %b want %b", tag, pulse, want);
    end
    assert (done === want_done) else begin
      miscompares++; $error("FAIL %s done got %b want %b", tag, done, want_done);
    end
  endtask

  function automatic logic [CH*CW-1:0] rand_cfg(input int hi);
    logic [CH*CW-1:0] c;
    for (int k = 0; k < CH; k++) c[k*CW +: CW] = CW'($urandom_range(hi, 0));
    return c;
  endfunction

  initial begin
    logic [CH*CW-1:0] cfg;
`ifdef STARTUP_SEQ_RESTART_EN
    restart_en = 1'b1;
`else
    restart_en = 1'b0;
`endif
    model_reset();
    rst_n = 1'b0; enable = 1'b0; restart = 1'b0; cfg_delay = '0;
    repeat (3) @(posedge clk);
    #1 check("reset");
    @(negedge clk) rst_n = 1'b1;

    // Directed timeline: delays {0,3,3,10}, E0 is the first step's edge.
    cfg = {8'd10, 8'd3, 8'd3, 8'd0};
    for (int e = 0; e <= 16; e++) begin
      step(1'b1, 1'b0, cfg, "timeline");
      if (e == 3)  expect_pulse(4'b0001, 1'b0, "E3");
      if (e == 6)  expect_pulse(4'b0110, 1'b0, "E6");
      if (e == 13) expect_pulse(4'b1000, 1'b1, "E13");
    end

    // Saturation: all delays at counter max release together after E258.
    repeat (4) step(1'b0, 1'b0, cfg, "drop");
    cfg = '1;
    for (int e = 0; e <= 262; e++) begin
      step(1'b1, 1'b0, cfg, "saturate");
      if (e == 258) expect_pulse(4'b1111, 1'b1, "E258");
    end

    // Enable drop mid-COUNT after channel 0 releases, then full restart.
    for (int r = 0; r < 4; r++) begin
      repeat (4) step(1'b0, 1'b0, cfg, "idle");
      cfg = rand_cfg(20);
      cfg[CW-1:0] = '0;
      cfg[CH*CW-1 -: CW] = 8'd20;
      for (int e = 0; e < 5 + int'($urandom_range(12, 0)); e++) step(1'b1, 1'b0, cfg, "drop_mid");
      repeat (4) step(1'b0, 1'b0, rand_cfg(20), "dropped");
      for (int e = 0; e < 28; e++) step(1'b1, 1'b0, cfg, "rerun");
    end

    // cfg change mid-COUNT must not affect the latched delay.
    repeat (4) step(1'b0, 1'b0, cfg, "idle");
    cfg = rand_cfg(15);
    cfg[CW +: CW] = 8'd5;
    for (int e = 0; e < 4; e++) step(1'b1, 1'b0, cfg, "latch");
    cfg[CW +: CW] = 8'd1;
    for (int e = 0; e < 20; e++) step(1'b1, 1'b0, cfg, "latched");

    // Asynchronous reset mid-COUNT.
    repeat (4) step(1'b0, 1'b0, cfg, "idle");
    cfg = {8'd12, 8'd9, 8'd4, 8'd1};
    for (int e = 0; e < 7; e++) step(1'b1, 1'b0, cfg, "pre_rst");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("async_rst");
    step(1'b1, 1'b0, cfg, "in_rst");
    #2 rst_n = 1'b1;
    for (int e = 0; e < 20; e++) step(1'b1, 1'b0, cfg, "post_rst");

    // Restart pulse in DONE (re-arms only when the macro is defined).
    for (int e = 0; e < 3; e++) step(1'b1, 1'b0, cfg, "done_hold");
    step(1'b1, 1'b1, {8'd3, 8'd2, 8'd0, 8'd1}, "restart");
    for (int e = 0; e < 10; e++) step(1'b1, 1'b0, cfg, "after_restart");

    // Random mix of enable, restart and configuration.
    for (int e = 0; e < 300; e++) begin
      if ($urandom_range(7, 0) == 0) cfg = rand_cfg(12);
      step($urandom_range(15, 0) != 0, $urandom_range(5, 0) == 0, cfg, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
